// File: rtl/dbg_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbg_slave_pkg
// Description : Shared types, default widths and helpers for the debug slave
//               command synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_slave_pkg;

    localparam int unsigned c_DBG_IR_W    = 2;
    localparam int unsigned c_DBG_SR_W    = 38;
    localparam int unsigned c_DBG_ACT_BIT = 34;

    // Command layout for the default build; the top re-derives it per instance.
    typedef struct packed {
        logic [c_DBG_IR_W-1:0] ir;
        logic [c_DBG_SR_W-1:0] data;
    } dbg_cmd_t;

    // One-hot decode of an IR value; callers truncate to 2**IR_W bits (IR_W <= 5).
    function automatic logic [31:0] onehot_ir(input logic [31:0] ir);
        onehot_ir = 32'd1 << ir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module      : dbg_strobe_sync
// Description : Multi-flop synchroniser with reset-safe rising-edge detect,
//               producing a registered single-cycle pulse in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev;
    logic                   r_armed;
    logic                   r_pulse;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];
    assign pulse   = r_pulse;

    // r_fill marks when the chain holds genuine post-reset samples; a rise only
    // counts once a genuine low level has been seen, so a strobe held high
    // across reset release is treated as already consumed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], strobe};
            r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev  <= w_level;
            r_armed <= r_armed | (r_fill[SYNC_STAGES-1] & ~w_level);
            r_pulse <= r_armed & w_level & ~r_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dbg_slave_cmd_sync.sv
`default_nettype none
// ============================================================================
// Module      : dbg_slave_cmd_sync
// Description : System-clock side of the JTAG debug slave: synchronised
//               update strobes, command FIFO and per-IR action pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_slave_cmd_sync
    import dbg_slave_pkg::*;
#(
    parameter int unsigned IR_W        = c_DBG_IR_W,
    parameter int unsigned SR_W        = c_DBG_SR_W,
    parameter int unsigned ACT_BIT     = c_DBG_ACT_BIT,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [IR_W-1:0]         ir_in,
    input  logic [SR_W-1:0]         sr,
    input  logic                    vs_uir,
    input  logic                    vs_udr,
    input  logic                    cmd_ready,
    input  logic                    ovf_clr,
    output logic                    cmd_valid,
    output logic [IR_W-1:0]         cmd_ir,
    output logic [SR_W-1:0]         jdo,
    output logic [(2**IR_W)-1:0]    take_action,
    output logic [(2**IR_W)-1:0]    take_no_action,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    ovf_sticky
);

    localparam int unsigned c_AW    = $clog2(DEPTH);
    localparam int unsigned c_LVL_W = c_AW + 1;
    localparam int unsigned c_NACT  = 2 ** IR_W;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } cmd_t;

    logic              w_uir_p;
    logic              w_udr_p;
    logic [IR_W-1:0]   r_ir_q;

    cmd_t              r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0] r_count;

    logic              r_cmd_valid;
    logic [IR_W-1:0]   r_cmd_ir;
    logic [SR_W-1:0]   r_jdo;
    logic [c_NACT-1:0] r_take_action;
    logic [c_NACT-1:0] r_take_no_action;
    logic              r_ovf;

    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic              w_drop;
    logic              w_load;
    cmd_t              w_head;
    logic [c_NACT-1:0] w_onehot;

    dbg_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_uir_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (vs_uir),
        .pulse   (w_uir_p)
    );

    dbg_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_udr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (vs_udr),
        .pulse   (w_udr_p)
    );

    // The count includes the entry mirrored in the head registers; it leaves
    // the FIFO only when popped.
    assign w_pop    = r_cmd_valid & cmd_ready;
    assign w_full   = (r_count == c_LVL_W'(DEPTH));
    assign w_push   = w_udr_p & (~w_full | w_pop);
    assign w_drop   = w_udr_p & w_full & ~w_pop;
    assign w_load   = ~r_cmd_valid & (r_count != '0);
    assign w_head   = r_mem[r_rd_ptr];
    assign w_onehot = c_NACT'(onehot_ir(32'(r_cmd_ir)));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{ir: r_ir_q, data: sr};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ir_q           <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_cmd_valid      <= 1'b0;
            r_cmd_ir         <= '0;
            r_jdo            <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
            r_ovf            <= 1'b0;
        end else begin
            if (w_uir_p) begin
                r_ir_q <= ir_in;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_LVL_W'(1);
                2'b01:   r_count <= r_count - c_LVL_W'(1);
                default: r_count <= r_count;
            endcase

            // Head data is held through the pulse cycle; the next head loads after.
            if (w_pop) begin
                r_cmd_valid <= 1'b0;
            end else if (w_load) begin
                r_cmd_valid <= 1'b1;
                r_cmd_ir    <= w_head.ir;
                r_jdo       <= w_head.data;
            end

            r_take_action    <= (w_pop &  r_jdo[ACT_BIT]) ? w_onehot : '0;
            r_take_no_action <= (w_pop & ~r_jdo[ACT_BIT]) ? w_onehot : '0;

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign cmd_valid      = r_cmd_valid;
    assign cmd_ir         = r_cmd_ir;
    assign jdo            = r_jdo;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign fifo_level     = r_count;
    assign ovf_sticky     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dbg_slave_cmd_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbg_slave_cmd_sync
// Description : Self-checking bench for the default and a widened build of
//               dbg_slave_cmd_sync against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbg_slave_cmd_sync;

    logic        clk = 1'b0;
    logic        reset_n, vs_uir, vs_udr, cmd_ready, ovf_clr;
    logic [2:0]  ir;
    logic [63:0] srv;

    logic        cv0, ovf0, cv1, ovf1;
    logic [1:0]  ci0;
    logic [2:0]  ci1;
    logic [37:0] jdo0;
    logic [43:0] jdo1;
    logic [3:0]  ta0, tna0;
    logic [7:0]  ta1, tna1;
    logic [2:0]  lvl0;
    logic [3:0]  lvl1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbg_slave_cmd_sync u_dut0 (
        .clk (clk), .reset_n (reset_n), .ir_in (ir[1:0]), .sr (srv[37:0]),
        .vs_uir (vs_uir), .vs_udr (vs_udr), .cmd_ready (cmd_ready), .ovf_clr (ovf_clr),
        .cmd_valid (cv0), .cmd_ir (ci0), .jdo (jdo0), .take_action (ta0),
        .take_no_action (tna0), .fifo_level (lvl0), .ovf_sticky (ovf0)
    );

    dbg_slave_cmd_sync #(
        .IR_W (3), .SR_W (44), .ACT_BIT (34), .DEPTH (8), .SYNC_STAGES (3)
    ) u_dut1 (
        .clk (clk), .reset_n (reset_n), .ir_in (ir), .sr (srv[43:0]),
        .vs_uir (vs_uir), .vs_udr (vs_udr), .cmd_ready (cmd_ready), .ovf_clr (ovf_clr),
        .cmd_valid (cv1), .cmd_ir (ci1), .jdo (jdo1), .take_action (ta1),
        .take_no_action (tna1), .fifo_level (lvl1), .ovf_sticky (ovf1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = default, 1 = wide) -------
    bit          m_live = 1'b0;
    int          mS [2], mD [2], cnt [2], qh [2], qn [2];
    logic [63:0] qd [2][16];
    logic [7:0]  qi [2][16];
    bit          mv [2], movf [2], mup [2], mip [2];
    logic [7:0]  mir [2], mirq [2], mta [2], mtn [2];
    logic [63:0] mjdo [2];
    logic [15:0] hu [2], hi [2];

    initial begin : model
        logic [63:0] msk;
        logic [7:0]  irm;
        bit          pop, acc;
        int          idx;
        mS[0] = 2; mS[1] = 3; mD[0] = 4; mD[1] = 8;
        for (int i = 0; i < 2; i++) begin
            hu[i] = '1; hi[i] = '1; cnt[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                msk = (i == 0) ? ((64'd1 << 38) - 64'd1) : ((64'd1 << 44) - 64'd1);
                irm = (i == 0) ? 8'h3 : 8'h7;
                if (!reset_n) begin
                    qn[i] = 0; qh[i] = 0; mv[i] = 0; mir[i] = 0; mjdo[i] = 0;
                    mta[i] = 0; mtn[i] = 0; movf[i] = 0; mirq[i] = 0;
                    mup[i] = 0; mip[i] = 0; cnt[i] = 0;
                    // A reset sample counts as "already high" for edge purposes.
                    hu[i] = {hu[i][14:0], 1'b1};
                    hi[i] = {hi[i][14:0], 1'b1};
                end else begin
                    pop = mv[i] && cmd_ready;
                    acc = mup[i] && (qn[i] < mD[i] || pop);
                    if (mup[i] && !acc)  movf[i] = 1'b1;
                    else if (ovf_clr)    movf[i] = 1'b0;
                    mta[i] = 0; mtn[i] = 0;
                    if (pop) begin
                        if (mjdo[i][34]) mta[i] = 8'd1 << mir[i];
                        else             mtn[i] = 8'd1 << mir[i];
                        qh[i] = (qh[i] + 1) % 16;
                        qn[i] = qn[i] - 1;
                        mv[i] = 1'b0;
                    end else if (!mv[i] && qn[i] > 0) begin
                        mv[i] = 1'b1; mir[i] = qi[i][qh[i]]; mjdo[i] = qd[i][qh[i]];
                    end
                    if (acc) begin
                        idx = (qh[i] + qn[i]) % 16;
                        qi[i][idx] = mirq[i];
                        qd[i][idx] = srv & msk;
                        qn[i] = qn[i] + 1;
                    end
                    if (mip[i]) mirq[i] = {5'd0, ir} & irm;
                    hu[i] = {hu[i][14:0], vs_udr};
                    hi[i] = {hi[i][14:0], vs_uir};
                    if (cnt[i] < 100) cnt[i]++;
                    mup[i] = (cnt[i] >= mS[i] + 1) && hu[i][mS[i]] && !hu[i][mS[i]+1];
                    mip[i] = (cnt[i] >= mS[i] + 1) && hi[i][mS[i]] && !hi[i][mS[i]+1];
                end
            end
            if (!reset_n) m_live = 1'b1;
        end
    end

    // ---------------- per-cycle compare against the model -------------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("d0 cmd_valid", 64'(cv0), 64'(mv[0]));
                chk("d0 cmd_ir", 64'(ci0), 64'(mir[0]));
                chk("d0 jdo", 64'(jdo0), mjdo[0]);
                chk("d0 take_action", 64'(ta0), 64'(mta[0]));
                chk("d0 take_no_action", 64'(tna0), 64'(mtn[0]));
                chk("d0 fifo_level", 64'(lvl0), 64'(qn[0]));
                chk("d0 ovf_sticky", 64'(ovf0), 64'(movf[0]));
                chk("d1 cmd_valid", 64'(cv1), 64'(mv[1]));
                chk("d1 cmd_ir", 64'(ci1), 64'(mir[1]));
                chk("d1 jdo", 64'(jdo1), mjdo[1]);
                chk("d1 take_action", 64'(ta1), 64'(mta[1]));
                chk("d1 take_no_action", 64'(tna1), 64'(mtn[1]));
                chk("d1 fifo_level", 64'(lvl1), 64'(qn[1]));
                chk("d1 ovf_sticky", 64'(ovf1), 64'(movf[1]));
            end
        end
    end

    // ---------------- stimulus and literal expectations ----------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_uir(input logic [2:0] v);
        ir = v; vs_uir = 1'b1; tick(8); vs_uir = 1'b0; tick(3);
    endtask

    task automatic send_udr(input logic [63:0] d);
        srv = d; vs_udr = 1'b1; tick(8); vs_udr = 1'b0; tick(3);
    endtask

    initial begin : stim
        int          lat0, lat1, n0, n1, ng0;
        logic [7:0]  or0, or1, nor0, nor1;
        logic [63:0] got0 [8];

        reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0; cmd_ready = 1'b0;
        ovf_clr = 1'b0; ir = '0; srv = '0;
        tick(3);
        chk("reset level", 64'(lvl0), 64'd0);
        chk("reset valid", 64'(cv0), 64'd0);
        chk("reset jdo", 64'(jdo0), 64'd0);
        reset_n = 1'b1;
        tick(6);

        // Single command with action, latency measured from first sampling edge.
        send_uir(3'd2);
        srv = 64'h4_1234_5678; vs_udr = 1'b1;
        lat0 = -1; lat1 = -1;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            if (cv0 && lat0 < 0) lat0 = e;
            if (cv1 && lat1 < 0) lat1 = e;
            if (e == 6) vs_udr = 1'b0;
        end
        chk("latency d0", 64'(lat0), 64'd4);
        chk("latency d1", 64'(lat1), 64'd5);
        chk("jdo d0", 64'(jdo0), 64'h4_1234_5678);
        chk("jdo d1", 64'(jdo1), 64'h4_1234_5678);
        chk("cmd_ir d0", 64'(ci0), 64'd2);
        cmd_ready = 1'b1;
        n0 = 0; n1 = 0; or0 = 0; or1 = 0;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            if (ta0 != 0) begin n0++; or0 = or0 | 8'(ta0); end
            if (ta1 != 0) begin n1++; or1 = or1 | ta1; end
        end
        chk("action pulses d0", 64'(n0), 64'd1);
        chk("action value d0", 64'(or0), 64'h4);
        chk("action pulses d1", 64'(n1), 64'd1);
        chk("action value d1", 64'(or1), 64'h4);
        cmd_ready = 1'b0;

        // No-action path.
        send_uir(3'd0);
        cmd_ready = 1'b1; srv = 64'hAB; vs_udr = 1'b1;
        or0 = 0; nor0 = 0; nor1 = 0;
        for (int e = 0; e < 14; e++) begin
            @(negedge clk);
            or0  = or0 | 8'(ta0);
            nor0 = nor0 | 8'(tna0);
            nor1 = nor1 | tna1;
            if (e == 7) vs_udr = 1'b0;
        end
        chk("no_action d0", 64'(nor0), 64'h1);
        chk("no_action d1", 64'(nor1), 64'h1);
        chk("no spurious action", 64'(or0), 64'h0);
        cmd_ready = 1'b0; tick(2);

        // Overflow: five pushes into a depth-4 FIFO.
        for (int k = 0; k < 5; k++) send_udr(64'h100 + 64'(k));
        chk("ovf level d0", 64'(lvl0), 64'd4);
        chk("ovf sticky d0", 64'(ovf0), 64'd1);
        chk("ovf level d1", 64'(lvl1), 64'd5);
        chk("ovf sticky d1", 64'(ovf1), 64'd0);
        cmd_ready = 1'b1; ng0 = 0;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            if ((ta0 | tna0) != 0 && ng0 < 8) begin got0[ng0] = 64'(jdo0); ng0++; end
        end
        chk("drain count", 64'(ng0), 64'd4);
        chk("drain first", got0[0], 64'h100);
        chk("drain fourth", got0[3], 64'h103);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        chk("ovf cleared", 64'(ovf0), 64'd0);
        cmd_ready = 1'b0;

        // Full FIFO with a pop coincident with the push pulse.
        for (int k = 0; k < 4; k++) send_udr(64'h200 + 64'(k));
        srv = 64'h2FF; vs_udr = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            if (e == 2) cmd_ready = 1'b1;
            if (e == 3) begin
                cmd_ready = 1'b0;
                chk("full pushpop level", 64'(lvl0), 64'd4);
                chk("full pushpop ovf", 64'(ovf0), 64'd0);
            end
            if (e == 7) vs_udr = 1'b0;
        end
        tick(3);
        cmd_ready = 1'b1; ng0 = 0;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            if ((ta0 | tna0) != 0 && ng0 < 8) begin got0[ng0] = 64'(jdo0); ng0++; end
        end
        chk("tail entry", got0[3], 64'h2FF);
        cmd_ready = 1'b0;

        // Reset mid-operation with the update strobe held high.
        for (int k = 0; k < 3; k++) send_udr(64'h300 + 64'(k));
        chk("pre-reset level", 64'(lvl0), 64'd3);
        vs_udr = 1'b1; tick(1);
        reset_n = 1'b0; tick(1); reset_n = 1'b1;
        chk("mid reset level", 64'(lvl0), 64'd0);
        chk("mid reset valid", 64'(cv0), 64'd0);
        chk("mid reset jdo", 64'(jdo0), 64'd0);
        tick(12);
        chk("held strobe no push d0", 64'(lvl0), 64'd0);
        chk("held strobe no push d1", 64'(lvl1), 64'd0);
        vs_udr = 1'b0; tick(5);
        send_udr(64'h4_0000_0055);
        chk("post reset push d0", 64'(lvl0), 64'd1);
        chk("post reset push d1", 64'(lvl1), 64'd1);
        cmd_ready = 1'b1; tick(8); cmd_ready = 1'b0;

        // Top IR value decodes to the highest pulse bit.
        send_uir(3'd7);
        cmd_ready = 1'b1; srv = 64'h4_0000_0007; vs_udr = 1'b1;
        or0 = 0; or1 = 0;
        for (int e = 0; e < 14; e++) begin
            @(negedge clk);
            or0 = or0 | 8'(ta0);
            or1 = or1 | ta1;
            if (e == 7) vs_udr = 1'b0;
        end
        chk("ir top bit d0", 64'(or0), 64'h8);
        chk("ir top bit d1", 64'(or1), 64'h80);
        cmd_ready = 1'b0; tick(2);

        // Randomised traffic: mixed strobes, bursty consumer, occasional clears.
        for (int it = 0; it < 60; it++) begin
            int k;
            srv = {$urandom, $urandom};
            ir  = 3'($urandom_range(0, 7));
            k   = $urandom_range(0, 3);
            vs_uir = (k != 1);
            vs_udr = (k != 0);
            for (int c = 0; c < 8; c++) begin
                cmd_ready = ((it % 8) < 5) ? ($urandom_range(0, 2) != 0) : 1'b0;
                ovf_clr   = ($urandom_range(0, 15) == 0);
                tick(1);
            end
            vs_uir = 1'b0; vs_udr = 1'b0;
            for (int c = 0; c < int'($urandom_range(2, 4)); c++) begin
                cmd_ready = ($urandom_range(0, 1) != 0);
                ovf_clr   = 1'b0;
                tick(1);
            end
        end
        ovf_clr = 1'b0; cmd_ready = 1'b1;
        tick(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
